// File: rtl/mcp3202_chan_sched.sv
// mcp3202_chan_sched
// Conversion scheduler for the MCP3202 SPI master. Produces the round tick,
// walks the enabled channels (CH0 then CH1) once per tick, hands each
// conversion to the SPI master and returns channel-tagged samples. Overruns
// (tick during an active round) and conversion timeouts are flagged sticky.
module mcp3202_chan_sched #(
  parameter int SAMPLE_DIV  = 200000,
  parameter int TIMEOUT_CYC = 20000,
  parameter bit DIFF_MODE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  ch_mask,
  input  logic        clr_err,
  output logic        adc_start,
  output logic        adc_sgl,
  output logic        adc_odd,
  input  logic        adc_busy,
  input  logic        adc_dv,
  input  logic [11:0] adc_data,
  output logic        smp_valid,
  output logic        smp_chan,
  output logic [11:0] smp_data,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_CONV  = 2'd3;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic             ch1_q, ch1_d;
  logic             dv_prev_q;
  logic             smp_valid_q, smp_valid_d;
  logic             smp_chan_q, smp_chan_d;
  logic [11:0]      smp_data_q, smp_data_d;
  logic             ovr_q, ovr_d;
  logic             terr_q, terr_d;
  logic             tick;
  logic             dv_rise;
  logic             start_c;
  logic             ovr_set;
  logic             tmo_set;
  logic             conv_done;
  logic             more_ch;

  assign tick    = en & (cnt_q == CNT_LAST);
  // A level-style data-valid only counts on the cycle it rises.
  assign dv_rise = adc_dv & ~dv_prev_q;
  // Only CH1 can follow CH0 within a round.
  assign more_ch = ~sel_q & ch1_q;

  // Round period counter: free-runs 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise.
  always_comb begin
    cnt_d = '0;
    if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Round sequencing: tick starts a round, each enabled channel is started and awaited in turn.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ch1_d       = ch1_q;
    tmo_d       = tmo_q;
    start_c     = 1'b0;
    tmo_set     = 1'b0;
    conv_done   = 1'b0;
    smp_valid_d = 1'b0;
    smp_chan_d  = smp_chan_q;
    smp_data_d  = smp_data_q;
    ovr_set     = tick & ((state_q == S_START) | (state_q == S_CONV));
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (tick && (ch_mask != 2'b00)) begin
          ch1_d   = ch_mask[1];
          sel_d   = ~ch_mask[0];
          state_d = S_START;
        end
      end
      S_START: begin
        if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
        if (!en) begin
          state_d = S_IDLE;
        end else if (!adc_busy) begin
          start_c = 1'b1;
          tmo_d   = '0;
          state_d = S_CONV;
        end
      end
      default: begin
        if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
        // A result arriving on the expiry cycle still counts as a good sample.
        if (dv_rise) begin
          smp_valid_d = 1'b1;
          smp_chan_d  = sel_q;
          smp_data_d  = adc_data;
          conv_done   = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          tmo_set   = 1'b1;
          conv_done = 1'b1;
        end
        if (conv_done) begin
          if (en && more_ch) begin
            sel_d   = 1'b1;
            state_d = S_START;
          end else if (en) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // Sticky error flags: a new error in the same cycle beats a clear request.
  always_comb begin
    ovr_d  = ovr_set ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
    terr_d = tmo_set ? 1'b1 : (clr_err ? 1'b0 : terr_q);
  end

  // State and output registers; reset drops any round in flight without emitting a sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      tmo_q       <= '0;
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      ch1_q       <= 1'b0;
      dv_prev_q   <= 1'b0;
      smp_valid_q <= 1'b0;
      smp_chan_q  <= 1'b0;
      smp_data_q  <= '0;
      ovr_q       <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      ch1_q       <= ch1_d;
      dv_prev_q   <= adc_dv;
      smp_valid_q <= smp_valid_d;
      smp_chan_q  <= smp_chan_d;
      smp_data_q  <= smp_data_d;
      ovr_q       <= ovr_d;
      terr_q      <= terr_d;
    end
  end

  assign adc_start   = start_c;
  assign adc_sgl     = ~DIFF_MODE;
  assign adc_odd     = sel_q;
  assign smp_valid   = smp_valid_q;
  assign smp_chan    = smp_chan_q;
  assign smp_data    = smp_data_q;
  assign overrun     = ovr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mcp3202_chan_sched.sv
// Bench for mcp3202_chan_sched: directed scenarios with literal expectations,
// then a long randomized run, all cross-checked every cycle against a
// queue-based behavioural model of the scheduler.
`timescale 1ns/1ps
module tb_mcp3202_chan_sched;

  localparam int DIV = 100;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  ch_mask = 2'b00;
  logic        clr_err = 1'b0;
  logic        adc_busy = 1'b0;
  logic        adc_dv = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic        adc_start, adc_sgl, adc_odd, smp_valid, smp_chan;
  logic [11:0] smp_data;
  logic        overrun, timeout_err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  mcp3202_chan_sched #(.SAMPLE_DIV(DIV), .TIMEOUT_CYC(TMO), .DIFF_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .clr_err(clr_err),
    .adc_start(adc_start), .adc_sgl(adc_sgl), .adc_odd(adc_odd),
    .adc_busy(adc_busy), .adc_dv(adc_dv), .adc_data(adc_data),
    .smp_valid(smp_valid), .smp_chan(smp_chan), .smp_data(smp_data),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_run = 0;          // consecutive enabled cycles, gives the period phase
  int  m_todo[$];          // channels of the current round still to be started
  bit  m_conv = 0;         // a conversion is outstanding
  int  m_cur = 0;
  int  m_age = 0;          // cycles spent waiting for the result
  bit  m_dvp = 0;
  bit  m_sv = 0;
  int  m_sch = 0;
  int  m_sdat = 0;
  bit  m_ovr = 0;
  bit  m_tmo = 0;

  always @(posedge clk) begin : model
    bit tk, done, oset, tset;
    if (rst) begin
      m_run = 0; m_todo.delete(); m_conv = 0; m_age = 0; m_dvp = 0;
      m_sv = 0; m_sch = 0; m_sdat = 0; m_ovr = 0; m_tmo = 0;
    end else begin
      tk   = en && ((m_run % DIV) == DIV - 1);
      oset = tk && (m_conv || m_todo.size() > 0);
      tset = 0;
      done = 0;
      m_sv = 0;
      if (m_conv) begin
        m_age++;
        if (adc_dv && !m_dvp) begin
          m_sv = 1; m_sch = m_cur; m_sdat = int'(adc_data); done = 1;
        end else if (m_age == TMO) begin
          tset = 1; done = 1;
        end
        if (done) begin
          m_conv = 0;
          if (!en) m_todo.delete();
        end
      end else if (m_todo.size() > 0) begin
        if (!en) m_todo.delete();
        else if (!adc_busy) begin
          m_cur = m_todo.pop_front(); m_conv = 1; m_age = 0;
        end
      end else if (tk) begin
        for (int c = 0; c < 2; c++) if (ch_mask[c]) m_todo.push_back(c);
      end
      m_ovr = oset ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
      m_tmo = tset ? 1'b1 : (clr_err ? 1'b0 : m_tmo);
      m_run = en ? m_run + 1 : 0;
      m_dvp = adc_dv;
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  int st_cyc[$];
  int st_odd[$];
  int sv_cyc[$];
  int sv_ch[$];
  int sv_dat[$];
  bit st_neg = 0;
  bit odd_neg = 0;
  int stcyc_neg = 0;

  always @(negedge clk) begin : compare
    bit e_start;
    if (rst) begin
      chk("rst_adc_start", 32'(adc_start), 0);
      chk("rst_adc_sgl", 32'(adc_sgl), 1);
      chk("rst_adc_odd", 32'(adc_odd), 0);
      chk("rst_smp_valid", 32'(smp_valid), 0);
      chk("rst_smp_chan", 32'(smp_chan), 0);
      chk("rst_smp_data", 32'(smp_data), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_timeout_err", 32'(timeout_err), 0);
    end else begin
      e_start = en && !m_conv && (m_todo.size() > 0) && !adc_busy;
      chk("adc_start", 32'(adc_start), 32'(e_start));
      chk("adc_sgl", 32'(adc_sgl), 1);
      if (m_conv) chk("adc_odd_conv", 32'(adc_odd), 32'(m_cur));
      else if (m_todo.size() > 0) chk("adc_odd_pend", 32'(adc_odd), 32'(m_todo[0]));
      chk("smp_valid", 32'(smp_valid), 32'(m_sv));
      if (m_sv) begin
        chk("smp_chan", 32'(smp_chan), 32'(m_sch));
        chk("smp_data", 32'(smp_data), 32'(m_sdat));
      end
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    end
    if (adc_start === 1'b1) begin
      st_cyc.push_back(cyc); st_odd.push_back(int'(adc_odd));
    end
    if (smp_valid === 1'b1) begin
      sv_cyc.push_back(cyc); sv_ch.push_back(int'(smp_chan)); sv_dat.push_back(int'(smp_data));
    end
    st_neg    = (adc_start === 1'b1);
    odd_neg   = adc_odd;
    stcyc_neg = cyc;
  end

  // ---------------- SPI master emulation ----------------
  int          cfg_delay = 10;   // >0 fixed, 0 random 1..45, <0 never answers
  int          cfg_busy = 0;     // 0 idle, 1 held busy, 2 random busy
  bit          cfg_spur = 0;
  bit          cfg_rdata = 0;
  logic [11:0] cfg_d0 = 12'h000;
  logic [11:0] cfg_d1 = 12'h000;
  int          due = -1;
  bit          due_ch = 0;

  always @(posedge clk) begin : emu
    int  dl, bm, d, stc;
    bit  sp, rd, st, och;
    logic [11:0] d0, d1;
    dl = cfg_delay; bm = cfg_busy; sp = cfg_spur; rd = cfg_rdata;
    d0 = cfg_d0; d1 = cfg_d1; st = st_neg; och = odd_neg; stc = stcyc_neg;
    #1;
    if (st) begin
      d = (dl == 0) ? int'($urandom_range(1, 45)) : dl;
      due = (dl < 0) ? -1 : stc + d;
      due_ch = och;
    end
    if (cyc == due) begin
      adc_dv = 1'b1;
      adc_data = rd ? 12'($urandom) : (due_ch ? d1 : d0);
    end else if (sp && ($urandom_range(0, 39) == 0)) begin
      adc_dv = 1'b1;
      adc_data = 12'($urandom);
    end else begin
      adc_dv = 1'b0;
      adc_data = rd ? 12'($urandom) : 12'h000;
    end
    adc_busy = (bm == 1) ? 1'b1 : ((bm == 2) ? ($urandom_range(0, 2) == 0) : 1'b0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios, then random ----------------
  initial begin : main
    int c0, bs, bv;
    rst = 1'b1;
    step(3);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_smp_valid", 32'(smp_valid), 0);
    chk("reset_adc_start", 32'(adc_start), 0);
    rst = 1'b0;
    step(3);

    // single channel: start 100 cycles after enable, sample 31 cycles after start
    cfg_delay = 30; cfg_d0 = 12'hABC;
    en = 1'b1; ch_mask = 2'b01; c0 = cyc; bs = st_cyc.size(); bv = sv_cyc.size();
    step(350);
    chk("A_nstart", 32'(st_cyc.size() - bs), 3);
    chk("A_first_start", 32'(st_cyc[bs] - c0), 100);
    chk("A_period", 32'(st_cyc[bs+1] - st_cyc[bs]), 100);
    chk("A_odd", 32'(st_odd[bs]), 0);
    chk("A_nsmp", 32'(sv_cyc.size() - bv), 3);
    chk("A_smp_lat", 32'(sv_cyc[bv] - st_cyc[bs]), 31);
    chk("A_smp_chan", 32'(sv_ch[bv]), 0);
    chk("A_smp_data", 32'(sv_dat[bv]), 32'h0ABC);
    en = 1'b0; step(5);

    // both channels per round
    cfg_delay = 20; cfg_d0 = 12'h123; cfg_d1 = 12'h456;
    en = 1'b1; ch_mask = 2'b11; bs = st_cyc.size(); bv = sv_cyc.size();
    step(160);
    chk("B_nstart", 32'(st_cyc.size() - bs), 2);
    chk("B_odd0", 32'(st_odd[bs]), 0);
    chk("B_odd1", 32'(st_odd[bs+1]), 1);
    chk("B_gap", 32'(st_cyc[bs+1] - st_cyc[bs]), 21);
    chk("B_nsmp", 32'(sv_cyc.size() - bv), 2);
    chk("B_ch0", 32'(sv_ch[bv]), 0);
    chk("B_d0", 32'(sv_dat[bv]), 32'h123);
    chk("B_ch1", 32'(sv_ch[bv+1]), 1);
    chk("B_d1", 32'(sv_dat[bv+1]), 32'h456);
    en = 1'b0; step(5);

    // overrun: master held busy across a second tick, then cleared
    cfg_delay = 30; cfg_busy = 1;
    en = 1'b1; ch_mask = 2'b01; bs = st_cyc.size(); bv = sv_cyc.size();
    step(210);
    chk("C_overrun_set", 32'(overrun), 1);
    chk("C_no_start_busy", 32'(st_cyc.size() - bs), 0);
    clr_err = 1'b1; step(1); clr_err = 1'b0; step(1);
    chk("C_overrun_clr", 32'(overrun), 0);
    cfg_busy = 0;
    step(60);
    chk("C_nstart", 32'(st_cyc.size() - bs), 1);
    chk("C_nsmp", 32'(sv_cyc.size() - bv), 1);
    en = 1'b0; step(5);

    // timeout on both channels, next channel started after expiry
    cfg_delay = -1;
    en = 1'b1; ch_mask = 2'b11; bs = st_cyc.size(); bv = sv_cyc.size();
    step(140);
    chk("D_tmo_early", 32'(timeout_err), 0);
    step(1);
    chk("D_tmo_set", 32'(timeout_err), 1);
    step(49);
    chk("D_nstart", 32'(st_cyc.size() - bs), 2);
    chk("D_gap", 32'(st_cyc[bs+1] - st_cyc[bs]), 41);
    chk("D_nsmp", 32'(sv_cyc.size() - bv), 0);
    clr_err = 1'b1; step(1); clr_err = 1'b0; step(1);
    chk("D_tmo_clr", 32'(timeout_err), 0);
    en = 1'b0; step(5);

    // busy for 20 cycles at tick delays the single start
    cfg_delay = 10;
    en = 1'b1; ch_mask = 2'b01; c0 = cyc; bs = st_cyc.size();
    step(99); cfg_busy = 1;
    step(20); cfg_busy = 0;
    step(30);
    chk("E_nstart", 32'(st_cyc.size() - bs), 1);
    chk("E_start_at", 32'(st_cyc[bs] - c0), 120);
    en = 1'b0; step(5);

    // enable dropped during CH0: sample delivered, CH1 skipped
    cfg_delay = 30; cfg_d0 = 12'h5A5; cfg_d1 = 12'h3C3;
    en = 1'b1; ch_mask = 2'b11; bs = st_cyc.size(); bv = sv_cyc.size();
    step(110); en = 1'b0;
    step(60);
    chk("F_nstart", 32'(st_cyc.size() - bs), 1);
    chk("F_nsmp", 32'(sv_cyc.size() - bv), 1);
    chk("F_ch", 32'(sv_ch[bv]), 0);
    chk("F_data", 32'(sv_dat[bv]), 32'h5A5);

    // reset in the middle of a conversion: no sample afterwards
    cfg_delay = 20;
    en = 1'b1; ch_mask = 2'b11; bs = st_cyc.size(); bv = sv_cyc.size();
    step(105); rst = 1'b1;
    step(2); rst = 1'b0;
    step(30);
    chk("G_nstart", 32'(st_cyc.size() - bs), 1);
    chk("G_nsmp", 32'(sv_cyc.size() - bv), 0);
    en = 1'b0; step(5);

    // randomized traffic against the model
    cfg_delay = 0; cfg_busy = 2; cfg_spur = 1; cfg_rdata = 1;
    en = 1'b1; ch_mask = 2'b11;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 36) == 0) ch_mask = 2'($urandom);
      clr_err = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 2499) == 0);
      step(1);
    end
    rst = 1'b0; clr_err = 1'b0; en = 1'b0;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
